// File: rtl/hfrv_trace_pkg.sv
// Shared types for the retired-instruction trace buffer: FSM states, capture modes,
// the reference entry layout and the fixed field widths.
package hfrv_trace_pkg;

    localparam int INSTR_W = 32;
    localparam int RD_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_POST    = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_TRIG    = 2'b10
    } mode_t;

    // Entry layout for the default 32-bit core, without the optional timestamp field.
    typedef struct packed {
        logic [31:0]         pc;
        logic [INSTR_W-1:0]  instr;
        logic [RD_W-1:0]     rd;
        logic [31:0]         wdata;
    } entry_t;

    // The reserved encoding falls back to ring capture.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_ONESHOT;
            2'b10:   return MODE_TRIG;
            default: return MODE_RING;
        endcase
    endfunction

endpackage

// File: rtl/hfrv_trace_mem.sv
// Trace entry storage: DEPTH x W register array with one synchronous write port
// and one asynchronous read port; storage is deliberately not reset.
module hfrv_trace_mem #(
    parameter int DEPTH = 64,
    parameter int W     = 101,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hfrv_trace_buffer.sv
// Retired-instruction trace buffer with ring, one-shot and PC-triggered capture.
// Define HFRV_TRACE_TIMESTAMP_EN to prepend a free-running cycle stamp to every entry.
module hfrv_trace_buffer
    import hfrv_trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int TS_W  = 32,
    localparam int AW   = $clog2(DEPTH),
`ifdef HFRV_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + XLEN + INSTR_W + RD_W + XLEN
`else
    localparam int ENTRY_W = XLEN + INSTR_W + RD_W + XLEN
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ret_valid,
    input  logic [XLEN-1:0]    ret_pc,
    input  logic [31:0]        ret_instr,
    input  logic [4:0]         ret_rd,
    input  logic [XLEN-1:0]    ret_wdata,
    input  logic [1:0]         mode,
    input  logic               arm,
    input  logic               stop,
    input  logic [XLEN-1:0]    trig_pc,
    input  logic [AW-1:0]      post_cnt,
    output logic               capturing,
    output logic               done,
    output logic [AW:0]        count,
    output logic               overflow,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_config
        $error("hfrv_trace_buffer: DEPTH must be a power of two >= 4 and TS_W >= 1");
    end

    state_t              state;
    mode_t               mode_q;
    logic [XLEN-1:0]     trig_q;
    logic [AW-1:0]       post_q;
    logic [AW-1:0]       remaining;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [ENTRY_W-1:0]  entry;
    logic                in_capture;
    logic                full;
    logic                write_en;
    logic                pop;
    logic                trig_hit;

    assign in_capture = (state == ST_CAPTURE) || (state == ST_POST);
    assign full       = (count == FULL);
    assign write_en   = !arm && ret_valid && in_capture && !(mode_q == MODE_ONESHOT && full);
    assign rd_valid   = (state == ST_DONE) && (count != '0);
    assign pop        = !arm && rd_valid && rd_ready;
    assign trig_hit   = (mode_q == MODE_TRIG) && (ret_pc == trig_q);

`ifdef HFRV_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign entry = {ts, ret_pc, ret_instr, ret_rd, ret_wdata};
`else
    assign entry = {ret_pc, ret_instr, ret_rd, ret_wdata};
`endif

    // A full write in ring/triggered capture evicts the oldest entry, so rd_ptr follows wr_ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_RING;
            trig_q    <= '0;
            post_q    <= '0;
            remaining <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            capturing <= 1'b0;
            done      <= 1'b0;
        end else if (arm) begin
            state     <= ST_CAPTURE;
            mode_q    <= decode_mode(mode);
            trig_q    <= trig_pc;
            post_q    <= post_cnt;
            remaining <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            capturing <= 1'b1;
            done      <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!full) begin
                    count <= count + 1'b1;
                end else begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    overflow <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
            case (state)
                ST_CAPTURE: begin
                    if (mode_q == MODE_RING && stop) begin
                        state     <= ST_DONE;
                        capturing <= 1'b0;
                        done      <= 1'b1;
                    end else if (write_en && mode_q == MODE_ONESHOT && count == FULL - 1'b1) begin
                        state     <= ST_DONE;
                        capturing <= 1'b0;
                        done      <= 1'b1;
                    end else if (write_en && trig_hit) begin
                        if (post_q == '0) begin
                            state     <= ST_DONE;
                            capturing <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state     <= ST_POST;
                            remaining <= post_q;
                        end
                    end
                end
                ST_POST: begin
                    if (write_en) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == AW'(1)) begin
                            state     <= ST_DONE;
                            capturing <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    hfrv_trace_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (write_en),
        .waddr (wr_ptr),
        .wdata (entry),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule
